// File: rtl/spi_txn_fsm.sv
// SPI transaction sequencer: header count, decode, then read-shift or write-commit. Outputs are registered, one clk after the deciding edge.
// There is no backpressure: SCLK pulses are consumed or dropped. The optional sticky abort flag is enabled with SPI_TXN_FSM_ERR_EN.
module spi_txn_fsm #(
   parameter int ADDR_BITS = 7,
   parameter int DATA_BITS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       sclk_pos,
   input  logic       sclk_neg,
   input  logic       rw_bit,
   output logic       addr_we,
   output logic       sr_we,
   output logic       dm_we,
   output logic       miso_buff,
   output logic [2:0] state,
   output logic       err
);

   localparam int CNT_MAX = (ADDR_BITS + 1 > DATA_BITS) ? ADDR_BITS + 1 : DATA_BITS;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HDR_LAST  = CW'(ADDR_BITS);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_HDR  = 3'd1,
      DECODE   = 3'd2,
      RD_LOAD  = 3'd3,
      RD_SHIFT = 3'd4,
      WR_GET   = 3'd5,
      WR_MEM   = 3'd6,
      DONE     = 3'd7
   } state_t;

   state_t          cur, nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            addr_we_nxt, sr_we_nxt, dm_we_nxt, miso_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur       <= IDLE;
         cnt       <= '0;
         addr_we   <= 1'b0;
         sr_we     <= 1'b0;
         dm_we     <= 1'b0;
         miso_buff <= 1'b0;
      end else begin
         cur       <= nxt;
         cnt       <= cnt_nxt;
         addr_we   <= addr_we_nxt;
         sr_we     <= sr_we_nxt;
         dm_we     <= dm_we_nxt;
         miso_buff <= miso_nxt;
      end
   end

   always_comb begin
      nxt         = cur;
      cnt_nxt     = cnt;
      addr_we_nxt = 1'b0;
      sr_we_nxt   = 1'b0;
      dm_we_nxt   = 1'b0;
      // cs deassert outranks every SCLK pulse and kills any pending strobe
      if (cs && cur != IDLE) begin
         nxt     = IDLE;
         cnt_nxt = '0;
      end else begin
         case (cur)
            IDLE: begin
               cnt_nxt = '0;
               if (!cs) nxt = GET_HDR;
            end
            GET_HDR: begin
               if (sclk_pos) begin
                  if (cnt == HDR_LAST) begin
                     nxt     = DECODE;
                     cnt_nxt = '0;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            DECODE: begin
               addr_we_nxt = 1'b1;
               nxt         = rw_bit ? RD_LOAD : WR_GET;
            end
            RD_LOAD: begin
               sr_we_nxt = 1'b1;
               nxt       = RD_SHIFT;
            end
            RD_SHIFT: begin
               if (sclk_neg) begin
                  if (cnt == DATA_LAST) begin
                     nxt     = DONE;
                     cnt_nxt = '0;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            WR_GET: begin
               if (sclk_pos) begin
                  if (cnt == DATA_LAST) begin
                     nxt     = WR_MEM;
                     cnt_nxt = '0;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            WR_MEM: begin
               dm_we_nxt = 1'b1;
               nxt       = DONE;
            end
            DONE: begin
               cnt_nxt = '0;
            end
            default: begin
               nxt     = IDLE;
               cnt_nxt = '0;
            end
         endcase
      end
      // MISO driver follows the state it is entering so it spans RD_SHIFT exactly
      miso_nxt = (nxt == RD_SHIFT);
   end

   assign state = cur;

`ifdef SPI_TXN_FSM_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (cs && cur != IDLE && cur != DONE) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
